// File: rtl/spike_window_counter.sv
// Spike-rate sampler: counts MN_spike rising edges over programmable windows of
// neuron_clk cycles and queues each window count in a first-word-fall-through FIFO.
module spike_window_counter #(
   parameter int CW = 32,
   parameter int AW = 4,
   parameter int DW = 16
) (
   input  logic          neuron_clk,
   input  logic          reset_sim,
   input  logic          MN_spike,
   input  logic [15:0]   spkid_MN,
   input  logic [31:0]   win_len,
   input  logic          rd_en,
   output logic [CW-1:0] fifo_dout,
   output logic          fifo_empty,
   output logic          fifo_full,
   output logic [AW:0]   fifo_level,
   output logic          win_done,
   output logic [CW-1:0] live_count,
   output logic [15:0]   last_spkid,
   output logic [DW-1:0] drop_cnt
);

   typedef enum logic {IDLE, COUNT} state_t;

   localparam int DEPTH = 1 << AW;

   state_t        state_q, state_d;
   logic          spike_prev_q, spike_prev_d;
   logic [31:0]   cyc_cnt_q, cyc_cnt_d;
   logic [31:0]   win_len_q, win_len_d;
   logic [CW-1:0] live_count_q, live_count_d;
   logic [15:0]   last_spkid_q, last_spkid_d;
   logic [DW-1:0] drop_cnt_q, drop_cnt_d;
   logic          win_done_q, win_done_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] mem_q [DEPTH];

   logic          spike_edge;
   logic          terminal;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [CW-1:0] close_val;

   always_ff @(posedge neuron_clk) begin
      if (reset_sim) begin
         state_q      <= IDLE;
         spike_prev_q <= 1'b0;
         cyc_cnt_q    <= '0;
         win_len_q    <= '0;
         live_count_q <= '0;
         last_spkid_q <= '0;
         drop_cnt_q   <= '0;
         win_done_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         spike_prev_q <= spike_prev_d;
         cyc_cnt_q    <= cyc_cnt_d;
         win_len_q    <= win_len_d;
         live_count_q <= live_count_d;
         last_spkid_q <= last_spkid_d;
         drop_cnt_q   <= drop_cnt_d;
         win_done_q   <= win_done_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge neuron_clk) begin
      if (push && !reset_sim) begin
         mem_q[wr_ptr_q[AW-1:0]] <= close_val;
      end
   end

   always_comb begin
      spike_edge = MN_spike & ~spike_prev_q;
      empty      = (wr_ptr_q == rd_ptr_q);
      full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      terminal   = (state_q == COUNT) && (cyc_cnt_q == win_len_q - 32'd1);
      close_val  = (&live_count_q) ? live_count_q : live_count_q + CW'(spike_edge);
      pop        = rd_en & ~empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the sample.
      push       = terminal & (~full | pop);
   end

   always_comb begin
      state_d      = state_q;
      spike_prev_d = MN_spike;
      cyc_cnt_d    = cyc_cnt_q;
      win_len_d    = win_len_q;
      live_count_d = live_count_q;
      last_spkid_d = spike_edge ? spkid_MN : last_spkid_q;
      drop_cnt_d   = drop_cnt_q;
      win_done_d   = 1'b0;
      wr_ptr_d     = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      case (state_q)
         IDLE: begin
            live_count_d = '0;
            if (win_len != '0) begin
               win_len_d = win_len;
               cyc_cnt_d = '0;
               state_d   = COUNT;
            end
         end
         COUNT: begin
            if (terminal) begin
               live_count_d = '0;
               cyc_cnt_d    = '0;
               win_done_d   = 1'b1;
               win_len_d    = win_len;
               if (win_len == '0) begin
                  state_d = IDLE;
               end
               if (!push && !(&drop_cnt_q)) begin
                  drop_cnt_d = drop_cnt_q + DW'(1);
               end
            end else begin
               live_count_d = close_val;
               cyc_cnt_d    = cyc_cnt_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_dout  = mem_q[rd_ptr_q[AW-1:0]];
      fifo_empty = empty;
      fifo_full  = full;
      fifo_level = wr_ptr_q - rd_ptr_q;
      win_done   = win_done_q;
      live_count = live_count_q;
      last_spkid = last_spkid_q;
      drop_cnt   = drop_cnt_q;
   end

endmodule

// File: tb/tb_spike_window_counter.sv
// Bench for spike_window_counter: a vector table for the basic window timing plus
// hand-written sequences, with window counts queued as expected FIFO contents.
module tb_spike_window_counter;

   localparam int CW = 32;
   localparam int AW = 4;
   localparam int DW = 16;

   logic          neuron_clk = 1'b0;
   logic          reset_sim;
   logic          MN_spike;
   logic [15:0]   spkid_MN;
   logic [31:0]   win_len;
   logic          rd_en;
   logic [CW-1:0] fifo_dout;
   logic          fifo_empty;
   logic          fifo_full;
   logic [AW:0]   fifo_level;
   logic          win_done;
   logic [CW-1:0] live_count;
   logic [15:0]   last_spkid;
   logic [DW-1:0] drop_cnt;

   int compared   = 0;
   int mismatched = 0;

   logic [CW-1:0] exp_q [$];

   typedef struct {
      logic          spike;
      logic [15:0]   id;
      logic [31:0]   wl;
      logic          exp_done;
      logic [CW-1:0] exp_live;
      logic [CW-1:0] exp_close;
   } vec_t;

   vec_t vecs [21];

   spike_window_counter #(.CW(CW), .AW(AW), .DW(DW)) dut (
      .neuron_clk (neuron_clk),
      .reset_sim  (reset_sim),
      .MN_spike   (MN_spike),
      .spkid_MN   (spkid_MN),
      .win_len    (win_len),
      .rd_en      (rd_en),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .fifo_level (fifo_level),
      .win_done   (win_done),
      .live_count (live_count),
      .last_spkid (last_spkid),
      .drop_cnt   (drop_cnt)
   );

   always #5 neuron_clk = ~neuron_clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one cycle's inputs, then return 1 time unit after the edge that samples them.
   task automatic applyStimulus(input logic spike, input logic [15:0] id, input logic [31:0] wl, input logic rd);
      MN_spike = spike;
      spkid_MN = id;
      win_len  = wl;
      rd_en    = rd;
      @(posedge neuron_clk);
      #1;
   endtask

   task automatic doReset();
      reset_sim = 1'b1;
      applyStimulus(1'b0, 16'h0, 32'd0, 1'b0);
      applyStimulus(1'b0, 16'h0, 32'd0, 1'b0);
      reset_sim = 1'b0;
   endtask

   task automatic drainCheck(input string name);
      logic [CW-1:0] expv;
      int            idx;
      idx = 0;
      checkOutput({name, "_level"}, fifo_level, exp_q.size());
      while (exp_q.size() > 0) begin
         expv = exp_q.pop_front();
         checkOutput($sformatf("%s_nonempty[%0d]", name, idx), fifo_empty, 1'b0);
         checkOutput($sformatf("%s_dout[%0d]", name, idx), fifo_dout, expv);
         applyStimulus(1'b0, 16'h0, 32'd0, 1'b1);
         idx++;
      end
      checkOutput({name, "_empty_end"}, fifo_empty, 1'b1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic       s;
      logic [1:0] cnt;
      reset_sim = 1'b0;
      MN_spike  = 1'b0;
      spkid_MN  = '0;
      win_len   = '0;
      rd_en     = 1'b0;

      // Test 1 table: 10-cycle windows, spikes at counting cycles 1, 4, 7 of the first window.
      for (int i = 0; i < 21; i++) begin
         vecs[i].spike     = 1'b0;
         vecs[i].id        = 16'h0;
         vecs[i].wl        = 32'd10;
         vecs[i].exp_done  = 1'b0;
         vecs[i].exp_live  = '0;
         vecs[i].exp_close = '0;
      end
      for (int i = 2; i < 10; i++) begin
         vecs[i].exp_live = (i >= 8) ? 3 : (i >= 5) ? 2 : 1;
      end
      vecs[2].spike  = 1'b1; vecs[2].id = 16'h0011;
      vecs[5].spike  = 1'b1; vecs[5].id = 16'h0022;
      vecs[8].spike  = 1'b1; vecs[8].id = 16'h0033;
      vecs[10].exp_done = 1'b1; vecs[10].exp_close = 3;
      vecs[20].exp_done = 1'b1; vecs[20].exp_close = 0; vecs[20].wl = 32'd0;

      doReset();
      checkOutput("rst_empty", fifo_empty, 1'b1);
      checkOutput("rst_full", fifo_full, 1'b0);
      checkOutput("rst_level", fifo_level, 0);
      checkOutput("rst_done", win_done, 1'b0);
      checkOutput("rst_live", live_count, 0);
      checkOutput("rst_spkid", last_spkid, 0);
      checkOutput("rst_drop", drop_cnt, 0);

      for (int i = 0; i < 21; i++) begin
         if (vecs[i].exp_done) exp_q.push_back(vecs[i].exp_close);
         applyStimulus(vecs[i].spike, vecs[i].id, vecs[i].wl, 1'b0);
         checkOutput($sformatf("t1_done[%0d]", i), win_done, vecs[i].exp_done);
         checkOutput($sformatf("t1_live[%0d]", i), live_count, vecs[i].exp_live);
      end
      checkOutput("t1_spkid", last_spkid, 16'h0033);
      drainCheck("t1");

      // Test 2: level held high across windows counts once.
      doReset();
      applyStimulus(1'b0, 16'h0, 32'd10, 1'b0);
      exp_q.push_back(1);
      exp_q.push_back(0);
      exp_q.push_back(0);
      for (int c = 0; c < 30; c++) begin
         applyStimulus(c < 25, 16'h0005, (c == 29) ? 32'd0 : 32'd10, 1'b0);
         if (c == 0) checkOutput("t2_live_first", live_count, 1);
         if (c == 24) checkOutput("t2_live_w3", live_count, 0);
      end
      drainCheck("t2");

      // Test 3: 20 four-cycle windows without reads; the last four overflow.
      doReset();
      applyStimulus(1'b0, 16'h0, 32'd4, 1'b0);
      for (int w = 0; w < 20; w++) begin
         cnt = (w % 3 == 0) ? 2'd1 : (w % 3 == 1) ? 2'd2 : 2'd0;
         if (w < 16) exp_q.push_back(CW'(cnt));
         for (int c = 0; c < 4; c++) begin
            s = ((w % 3 == 0) && c == 1) || ((w % 3 == 1) && (c == 0 || c == 2));
            applyStimulus(s, 16'(w), 32'd4, 1'b0);
         end
         if (w == 15) begin
            checkOutput("t3_full16", fifo_full, 1'b1);
            checkOutput("t3_level16", fifo_level, 16);
            checkOutput("t3_drop16", drop_cnt, 0);
         end
      end
      checkOutput("t3_done_dropped", win_done, 1'b1);
      checkOutput("t3_drop20", drop_cnt, 4);
      checkOutput("t3_level20", fifo_level, 16);
      checkOutput("t3_head", fifo_dout, 1);

      // Test 4: pop in the terminal cycle of a full FIFO, so the new sample is kept.
      applyStimulus(1'b0, 16'd20, 32'd4, 1'b0);
      applyStimulus(1'b1, 16'd20, 32'd4, 1'b0);
      applyStimulus(1'b0, 16'd20, 32'd4, 1'b0);
      checkOutput("t4_head", fifo_dout, exp_q[0]);
      void'(exp_q.pop_front());
      exp_q.push_back(1);
      applyStimulus(1'b0, 16'd20, 32'd0, 1'b1);
      checkOutput("t4_level", fifo_level, 16);
      checkOutput("t4_full", fifo_full, 1'b1);
      checkOutput("t4_drop", drop_cnt, 4);
      checkOutput("t4_done", win_done, 1'b1);
      drainCheck("t4");

      // Test 5: single-cycle windows with alternating pulses.
      doReset();
      applyStimulus(1'b0, 16'h0, 32'd1, 1'b0);
      for (int c = 0; c < 8; c++) begin
         exp_q.push_back((c % 2 == 0) ? 1 : 0);
         applyStimulus(c % 2 == 0, 16'h0100 + 16'(c), (c == 7) ? 32'd0 : 32'd1, 1'b0);
         checkOutput($sformatf("t5_done[%0d]", c), win_done, 1'b1);
         checkOutput($sformatf("t5_spkid[%0d]", c), last_spkid, 16'h0100 + 16'(c - (c % 2)));
      end
      drainCheck("t5");

      // Test 6: length change 8->5 mid-window, then reset with two queued entries.
      doReset();
      applyStimulus(1'b0, 16'h0, 32'd8, 1'b0);
      for (int c = 0; c < 15; c++) begin
         s = (c == 0) || (c == 9) || (c == 11) || (c == 13);
         applyStimulus(s, 16'h0060, (c < 3) ? 32'd8 : 32'd5, 1'b0);
         checkOutput($sformatf("t6_done[%0d]", c), win_done, (c == 7) || (c == 12));
      end
      checkOutput("t6_live_pre", live_count, 1);
      checkOutput("t6_level_pre", fifo_level, 2);
      checkOutput("t6_head_pre", fifo_dout, 1);
      reset_sim = 1'b1;
      applyStimulus(1'b1, 16'h0060, 32'd5, 1'b0);
      reset_sim = 1'b0;
      checkOutput("t6_empty", fifo_empty, 1'b1);
      checkOutput("t6_live", live_count, 0);
      checkOutput("t6_drop", drop_cnt, 0);
      checkOutput("t6_level", fifo_level, 0);
      applyStimulus(1'b1, 16'h0077, 32'd0, 1'b0);
      checkOutput("t6_first_edge_spkid", last_spkid, 16'h0077);
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 16'h0, 32'd0, 1'b0);
      end
      checkOutput("t6_still_empty", fifo_empty, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
